mpmc10_strip_seq: RTL and testbench
===================================

Name: mpmc10_strip_seq

Overview:
- Per-channel burst sequencer for the mpmc10 memory controller.
- Accepts one request at a time from the port arbiter: address, read/write, strip count.
- Drives the MIG-style app command/write-data handshakes.
- Produces state, strip_cnt, num_strips and addr_base. mpmc10_addr_gen in the parent consumes these to step the 16-byte strip address.

Parameters:
- TO_LIMIT, 1023, watchdog cycle limit; used only with MPMC10_TIMEOUT_EN.

Ports:
- clk  in  1  controller clock
- rst  in  1  synchronous active-high reset
- req  in  1  request valid; held until req_ack
- req_we  in  1  1=write, 0=read
- req_adr  in  32  request byte address; bits [3:0] ignored
- req_num_strips  in  6  read strips minus one; ignored for writes
- req_ack  out  1  one-cycle accept pulse
- state  out  mpmc10_state_t  current sequencer state
- num_strips  out  6  latched strip count
- strip_cnt  out  6  read commands accepted so far
- rd_strip_cnt  out  6  read data beats received
- addr_base  out  32  latched address, bits [3:0] forced to 0
- app_rdy  in  1  memory accepts command
- app_en  out  1  command valid
- app_cmd  out  3  3'b001 read, 3'b000 write
- app_wdf_rdy  in  1  write FIFO ready
- app_wdf_wren  out  1  write data valid
- app_wdf_end  out  1  last write beat; equals app_wdf_wren
- app_rd_data_valid  in  1  read data beat valid
- done  out  1  one-cycle completion pulse
- err  out  1  timeout pulse; tied 0 without MPMC10_TIMEOUT_EN

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset (any cycle, including mid-burst):
  - state=IDLE.
  - All counters, addr_base, num_strips, app_en, app_wdf_wren, req_ack, done and err are 0.
  - app_cmd = 3'b001.
- IDLE: on req, go to PRESET1. A request is never accepted in any other state.
- PRESET1:
  - req_ack=1 for this cycle.
  - Latch addr_base={req_adr[31:4],4'h0}.
  - Latch num_strips = req_we ? 0 : req_num_strips.
  - Clear strip_cnt and rd_strip_cnt.
  - Go to PRESET2.
- PRESET2: one cycle, during which the address generator loads addr_base. Then go to READ_DATA0 if read, WRITE_DATA0 if write.
- READ_DATA0: go to READ_DATA1 next cycle with app_en=1 and app_cmd=read.
- READ_DATA1:
  - Hold app_en until app_rdy.
  - On app_rdy with strip_cnt!=num_strips: strip_cnt+1 and stay. This matches the address generator's increment rule.
  - On app_rdy with strip_cnt==num_strips: drop app_en and go to READ_DATA2.
  - Total commands issued = num_strips+1.
- rd_strip_cnt increments on every app_rd_data_valid in READ_DATA1 or READ_DATA2. Data may return while commands are still being issued.
- READ_DATA2:
  - Exit when all num_strips+1 beats are in: rd_strip_cnt==num_strips with app_rd_data_valid, or rd_strip_cnt already past num_strips.
  - On exit: done=1 for one cycle, go to IDLE.
- WRITE_DATA0: app_wdf_wren=app_wdf_end=1 until app_wdf_rdy, then go to WRITE_DATA1.
- WRITE_DATA1:
  - app_en=1, app_cmd=write until app_rdy.
  - On app_rdy: go to WRITE_DATA3, strip_cnt+1.
- WRITE_DATA3: done=1 for one cycle, go to IDLE.
- Widths: all counters are 6-bit with no wrap. num_strips max 63 gives 64 strips.
- Extra app_rd_data_valid outside READ_DATA1/READ_DATA2 is ignored.
- app_rdy outside a state that drives app_en is ignored.
- Latency: req to first app_en is 3 cycles (PRESET1, PRESET2, READ_DATA0 or WRITE_DATA0).

Optional Feature:
- Macro: MPMC10_TIMEOUT_EN.
- Defined:
  - A 10-bit watchdog clears on every state change, app_rdy, app_wdf_rdy or app_rd_data_valid.
  - In any non-IDLE state it counts up. On reaching TO_LIMIT: err=1 for one cycle, drop app_en and app_wdf_wren, go to IDLE, no done.
- Undefined: no watchdog; err tied 0; the sequencer waits indefinitely.

Decomposition:
- Package mpmc10_pkg holds:
  - mpmc10_state_t, which must include IDLE, PRESET1, PRESET2, READ_DATA0, READ_DATA1, READ_DATA2, WRITE_DATA0, WRITE_DATA1, WRITE_DATA3.
  - Constants CMD_READ=3'b001 and CMD_WRITE=3'b000.
- One sub-module, mpmc10_rd_beat_cnt: the rd_strip_cnt counter with completion compare.
- The address generator stays external, in the parent.

Test Plan:
- Read, req_adr=32'h0000_1234, req_num_strips=3, app_rdy always 1, data 2 cycles after each command:
  - addr_base=32'h0000_1230.
  - Exactly 4 app_en cycles; strip_cnt ends at 3.
  - done one cycle after the 4th beat.
- Read, num_strips=0, app_rdy low 5 cycles: app_en held 5 cycles; one command; done after 1 beat.
- Write, req_adr=32'h8000_0040, app_wdf_rdy delayed 2 cycles:
  - wren/end high 2 cycles, then app_en with app_cmd=0.
  - done; num_strips=0 even with req_num_strips=7.
- rst asserted in READ_DATA1 with strip_cnt=2: next cycle state=IDLE, all outputs at reset values; a following request proceeds normally.
- req held high through an entire burst: single req_ack; second req_ack only after return to IDLE.
- With MPMC10_TIMEOUT_EN and TO_LIMIT=16, app_rdy stuck 0: err pulse at cycle 16 of READ_DATA1, state=IDLE, no done.

Source files
------------

// File: rtl/mpmc10_strip_seq_pkg.sv
// Shared types and constants for the mpmc10 per-channel strip sequencer.
package mpmc10_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRESET1,
    PRESET2,
    READ_DATA0,
    READ_DATA1,
    READ_DATA2,
    WRITE_DATA0,
    WRITE_DATA1,
    WRITE_DATA3
  } mpmc10_state_t;

  localparam logic [2:0] CMD_READ  = 3'b001;
  localparam logic [2:0] CMD_WRITE = 3'b000;

  localparam int STRIP_W = 6;
  localparam int WD_W    = 10;

endpackage

// File: rtl/mpmc10_strip_seq_rd_beat_cnt.sv
// Read-beat counter for one burst, with the "all beats returned" compare.
module mpmc10_rd_beat_cnt
  import mpmc10_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               beat,
  input  logic [STRIP_W-1:0] num_strips,
  output logic [STRIP_W-1:0] cnt,
  output logic               all_in
);

  localparam logic [STRIP_W-1:0] CNT_MAX = '1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (beat && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Last beat arriving now, or every beat already counted.
  assign all_in = (beat && cnt == num_strips) || (cnt > num_strips);

endmodule

// File: rtl/mpmc10_strip_seq.sv
// mpmc10 per-channel burst sequencer driving the MIG app command/write-data handshakes.
// Optional watchdog abort enabled by defining MPMC10_TIMEOUT_EN.
module mpmc10_strip_seq
  import mpmc10_pkg::*;
#(
  parameter int TO_LIMIT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req,
  input  logic               req_we,
  input  logic [31:0]        req_adr,
  input  logic [STRIP_W-1:0] req_num_strips,
  output logic               req_ack,
  output mpmc10_state_t      state,
  output logic [STRIP_W-1:0] num_strips,
  output logic [STRIP_W-1:0] strip_cnt,
  output logic [STRIP_W-1:0] rd_strip_cnt,
  output logic [31:0]        addr_base,
  input  logic               app_rdy,
  output logic               app_en,
  output logic [2:0]         app_cmd,
  input  logic               app_wdf_rdy,
  output logic               app_wdf_wren,
  output logic               app_wdf_end,
  input  logic               app_rd_data_valid,
  output logic               done,
  output logic               err
);

  logic is_write;
  logic rd_beat;
  logic rd_all_in;
  logic to_hit;
  logic unused_adr;

  assign unused_adr  = ^req_adr[3:0];
  assign app_wdf_end = app_wdf_wren;
  assign rd_beat     = app_rd_data_valid && (state == READ_DATA1 || state == READ_DATA2);

  mpmc10_rd_beat_cnt u_rd_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == PRESET1),
    .beat       (rd_beat),
    .num_strips (num_strips),
    .cnt        (rd_strip_cnt),
    .all_in     (rd_all_in)
  );

`ifdef MPMC10_TIMEOUT_EN
  logic [WD_W-1:0] wd;
  logic            activity;
  logic            stalled;

  assign activity = app_rdy | app_wdf_rdy | app_rd_data_valid;
  assign stalled  = state inside {READ_DATA1, READ_DATA2, WRITE_DATA0, WRITE_DATA1};

  // Waiting states leave only on a handshake, so clearing on activity or a transient
  // state covers every state change. wd holds completed idle cycles of the wait.
  always_ff @(posedge clk) begin
    if (rst || !stalled || activity) begin
      wd <= '0;
    end else begin
      wd <= wd + 1'b1;
    end
  end

  // Abort on the edge closing wait cycle TO_LIMIT-1 so err shows in cycle TO_LIMIT.
  assign to_hit = stalled && !activity && (wd == WD_W'(TO_LIMIT - 2));
`else
  logic unused_to_limit;

  assign unused_to_limit = ^WD_W'(TO_LIMIT);
  assign to_hit          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ack      <= 1'b0;
      num_strips   <= '0;
      strip_cnt    <= '0;
      addr_base    <= '0;
      is_write     <= 1'b0;
      app_en       <= 1'b0;
      app_cmd      <= CMD_READ;
      app_wdf_wren <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      req_ack <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            req_ack <= 1'b1;
            state   <= PRESET1;
          end
        end
        PRESET1: begin
          addr_base  <= {req_adr[31:4], 4'h0};
          num_strips <= req_we ? '0 : req_num_strips;
          is_write   <= req_we;
          strip_cnt  <= '0;
          state      <= PRESET2;
        end
        PRESET2: begin
          // Write data is staged before the command, so wren rises on entry to WRITE_DATA0.
          if (is_write) begin
            app_wdf_wren <= 1'b1;
            state        <= WRITE_DATA0;
          end else begin
            state <= READ_DATA0;
          end
        end
        READ_DATA0: begin
          app_en  <= 1'b1;
          app_cmd <= CMD_READ;
          state   <= READ_DATA1;
        end
        READ_DATA1: begin
          if (app_rdy) begin
            if (strip_cnt != num_strips) begin
              strip_cnt <= strip_cnt + 1'b1;
            end else begin
              app_en <= 1'b0;
              state  <= READ_DATA2;
            end
          end
        end
        READ_DATA2: begin
          if (rd_all_in) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        WRITE_DATA0: begin
          if (app_wdf_rdy) begin
            app_wdf_wren <= 1'b0;
            app_en       <= 1'b1;
            app_cmd      <= CMD_WRITE;
            state        <= WRITE_DATA1;
          end
        end
        WRITE_DATA1: begin
          if (app_rdy) begin
            app_en    <= 1'b0;
            strip_cnt <= strip_cnt + 1'b1;
            done      <= 1'b1;
            state     <= WRITE_DATA3;
          end
        end
        WRITE_DATA3: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (to_hit) begin
        err          <= 1'b1;
        app_en       <= 1'b0;
        app_wdf_wren <= 1'b0;
        state        <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_mpmc10_strip_seq.sv
// Directed self-checking bench for mpmc10_strip_seq; covers the watchdog when MPMC10_TIMEOUT_EN is defined.
module tb_mpmc10_strip_seq;
  import mpmc10_pkg::*;

`ifdef MPMC10_TIMEOUT_EN
  localparam int TB_TO_LIMIT = 16;
`else
  localparam int TB_TO_LIMIT = 1023;
`endif

  logic          clk;
  logic          rst;
  logic          req;
  logic          req_we;
  logic [31:0]   req_adr;
  logic [5:0]    req_num_strips;
  logic          req_ack;
  mpmc10_state_t state;
  logic [5:0]    num_strips;
  logic [5:0]    strip_cnt;
  logic [5:0]    rd_strip_cnt;
  logic [31:0]   addr_base;
  logic          app_rdy;
  logic          app_en;
  logic [2:0]    app_cmd;
  logic          app_wdf_rdy;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_rd_data_valid;
  logic          done;
  logic          err;

  int vectors;
  int miscompares;

  // Observations recorded by run_burst for the calling test to judge.
  int            ack_cnt, en_cnt, cmd_cnt, wren_cnt, beats, done_cnt;
  int            done_cyc, first_en, last_wren, last_beat;
  logic          seen_done, cmd_bad, end_bad;
  mpmc10_state_t done_state;
  logic [3:0]    pipe;

  mpmc10_strip_seq #(.TO_LIMIT(TB_TO_LIMIT)) dut (
    .clk               (clk),
    .rst               (rst),
    .req               (req),
    .req_we            (req_we),
    .req_adr           (req_adr),
    .req_num_strips    (req_num_strips),
    .req_ack           (req_ack),
    .state             (state),
    .num_strips        (num_strips),
    .strip_cnt         (strip_cnt),
    .rd_strip_cnt      (rd_strip_cnt),
    .addr_base         (addr_base),
    .app_rdy           (app_rdy),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_wdf_rdy       (app_wdf_rdy),
    .app_wdf_wren      (app_wdf_wren),
    .app_wdf_end       (app_wdf_end),
    .app_rd_data_valid (app_rd_data_valid),
    .done              (done),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays memory: app_rdy held low for rdy_low app_en cycles,
  // app_wdf_rdy low for wdf_low wren cycles, read data 2 cycles after each accepted command.
  task automatic run_burst(input logic we, input logic [31:0] adr, input logic [5:0] ns,
                           input int rdy_low, input int wdf_low, input logic hold);
    logic [2:0] exp_cmd;
    exp_cmd   = we ? 3'b000 : 3'b001;
    ack_cnt   = 0; en_cnt = 0; cmd_cnt = 0; wren_cnt = 0; beats = 0; done_cnt = 0;
    done_cyc  = -1; first_en = -1; last_wren = -1; last_beat = -1;
    seen_done = 1'b0; cmd_bad = 1'b0; end_bad = 1'b0; done_state = IDLE;
    pipe      = '0;
    req = 1'b1; req_we = we; req_adr = adr; req_num_strips = ns;
    for (int c = 0; c < 200 && !seen_done; c++) begin
      tick();
      if (req_ack) begin
        ack_cnt++;
        if (!hold) req = 1'b0;
      end
      if (done) begin
        done_cnt++; seen_done = 1'b1; done_cyc = c; done_state = state;
      end
      if (app_en && first_en < 0) first_en = c;
      if (app_en && app_cmd !== exp_cmd) cmd_bad = 1'b1;
      app_rdy = (en_cnt >= rdy_low);
      if (app_en) begin
        en_cnt++;
        if (app_rdy) cmd_cnt++;
      end
      app_wdf_rdy = (wren_cnt >= wdf_low);
      if (app_wdf_wren) begin
        wren_cnt++; last_wren = c;
      end
      if (app_wdf_end !== app_wdf_wren) end_bad = 1'b1;
      app_rd_data_valid = pipe[0];
      if (pipe[0]) begin
        beats++; last_beat = c;
      end
      pipe = pipe >> 1;
      if (app_en && app_rdy) pipe[2] = 1'b1;
    end
    if (!hold) req = 1'b0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (state !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d want %0d", state, IDLE);
    end
    vectors++;
    if ({req_ack, app_en, app_wdf_wren, app_wdf_end, done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_pulses: got %b want 000000", {req_ack, app_en, app_wdf_wren, app_wdf_end, done, err});
    end
    vectors++;
    if (app_cmd !== 3'b001) begin
      miscompares++; $display("FAIL reset_app_cmd: got %b want 001", app_cmd);
    end
    vectors++;
    if ({num_strips, strip_cnt, rd_strip_cnt} !== 18'h0 || addr_base !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got ns=%0d sc=%0d rc=%0d ab=%h want all 0", num_strips, strip_cnt, rd_strip_cnt, addr_base);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (state !== IDLE) begin
      miscompares++; $display("FAIL reset_release: got %0d want %0d", state, IDLE);
    end
  endtask

  task automatic test_stray_inputs();
    app_rd_data_valid = 1'b1; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) tick();
    app_rd_data_valid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    vectors++;
    if (state !== IDLE) begin
      miscompares++; $display("FAIL stray_state: got %0d want %0d", state, IDLE);
    end
    vectors++;
    if (rd_strip_cnt !== 6'd0) begin
      miscompares++; $display("FAIL stray_rd_cnt: got %0d want 0", rd_strip_cnt);
    end
    vectors++;
    if ({app_en, app_wdf_wren, done} !== 3'b0) begin
      miscompares++; $display("FAIL stray_outputs: got %b want 000", {app_en, app_wdf_wren, done});
    end
  endtask

  task automatic test_read_burst();
    run_burst(1'b0, 32'h0000_1234, 6'd3, 0, 0, 1'b0);
    vectors++;
    if (!seen_done) begin
      miscompares++; $display("FAIL rd4_timeout: got no done want done");
    end
    vectors++;
    if (addr_base !== 32'h0000_1230) begin
      miscompares++; $display("FAIL rd4_addr_base: got %h want 00001230", addr_base);
    end
    vectors++;
    if (num_strips !== 6'd3) begin
      miscompares++; $display("FAIL rd4_num_strips: got %0d want 3", num_strips);
    end
    vectors++;
    if (en_cnt !== 4 || cmd_cnt !== 4) begin
      miscompares++; $display("FAIL rd4_app_en: got en=%0d cmd=%0d want 4/4", en_cnt, cmd_cnt);
    end
    vectors++;
    if (strip_cnt !== 6'd3) begin
      miscompares++; $display("FAIL rd4_strip_cnt: got %0d want 3", strip_cnt);
    end
    vectors++;
    if (beats !== 4 || rd_strip_cnt !== 6'd4) begin
      miscompares++; $display("FAIL rd4_beats: got beats=%0d rc=%0d want 4/4", beats, rd_strip_cnt);
    end
    vectors++;
    if (done_cyc !== last_beat + 1) begin
      miscompares++; $display("FAIL rd4_done_timing: got %0d want %0d", done_cyc, last_beat + 1);
    end
    vectors++;
    if (first_en !== 3) begin
      miscompares++; $display("FAIL rd4_latency: got %0d want 3", first_en);
    end
    vectors++;
    if (cmd_bad !== 1'b0) begin
      miscompares++; $display("FAIL rd4_app_cmd: got bad=%b want 0", cmd_bad);
    end
    vectors++;
    if (done_state !== IDLE || ack_cnt !== 1) begin
      miscompares++; $display("FAIL rd4_end: got st=%0d acks=%0d want %0d/1", done_state, ack_cnt, IDLE);
    end
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++; $display("FAIL rd4_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_read_stall();
    run_burst(1'b0, 32'h0000_0100, 6'd0, 5, 0, 1'b0);
    vectors++;
    if (!seen_done) begin
      miscompares++; $display("FAIL rd1_timeout: got no done want done");
    end
    // 5 stalled cycles plus the accepting cycle.
    vectors++;
    if (en_cnt !== 6 || cmd_cnt !== 1) begin
      miscompares++; $display("FAIL rd1_app_en: got en=%0d cmd=%0d want 6/1", en_cnt, cmd_cnt);
    end
    vectors++;
    if (beats !== 1 || rd_strip_cnt !== 6'd1 || strip_cnt !== 6'd0) begin
      miscompares++;
      $display("FAIL rd1_counts: got beats=%0d rc=%0d sc=%0d want 1/1/0", beats, rd_strip_cnt, strip_cnt);
    end
    vectors++;
    if (done_cyc !== last_beat + 1 || done_cnt !== 1) begin
      miscompares++; $display("FAIL rd1_done: got cyc=%0d n=%0d want %0d/1", done_cyc, done_cnt, last_beat + 1);
    end
    tick();
  endtask

  task automatic test_write();
    run_burst(1'b1, 32'h8000_0040, 6'd7, 0, 1, 1'b0);
    vectors++;
    if (!seen_done) begin
      miscompares++; $display("FAIL wr_timeout: got no done want done");
    end
    vectors++;
    if (wren_cnt !== 2 || end_bad !== 1'b0) begin
      miscompares++; $display("FAIL wr_wren: got n=%0d end_bad=%b want 2/0", wren_cnt, end_bad);
    end
    vectors++;
    if (en_cnt !== 1 || cmd_bad !== 1'b0) begin
      miscompares++; $display("FAIL wr_cmd: got en=%0d cmd_bad=%b want 1/0", en_cnt, cmd_bad);
    end
    vectors++;
    if (first_en !== last_wren + 1) begin
      miscompares++; $display("FAIL wr_order: got %0d want %0d", first_en, last_wren + 1);
    end
    vectors++;
    if (done_state !== WRITE_DATA3 || done_cyc !== 5) begin
      miscompares++; $display("FAIL wr_done: got st=%0d cyc=%0d want %0d/5", done_state, done_cyc, WRITE_DATA3);
    end
    vectors++;
    if (num_strips !== 6'd0) begin
      miscompares++; $display("FAIL wr_num_strips: got %0d want 0", num_strips);
    end
    vectors++;
    if (addr_base !== 32'h8000_0040 || strip_cnt !== 6'd1) begin
      miscompares++; $display("FAIL wr_regs: got ab=%h sc=%0d want 80000040/1", addr_base, strip_cnt);
    end
    tick();
    vectors++;
    if (state !== IDLE || done !== 1'b0) begin
      miscompares++; $display("FAIL wr_return: got st=%0d done=%b want %0d/0", state, done, IDLE);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic found;
    found = 1'b0;
    req = 1'b1; req_we = 1'b0; req_adr = 32'h0000_2000; req_num_strips = 6'd5;
    app_rdy = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      tick();
      if (req_ack) req = 1'b0;
      if (state == READ_DATA1 && strip_cnt == 6'd2) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL mid_reach: got no READ_DATA1/strip 2 want reached");
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; app_rdy = 1'b0; req = 1'b0;
    vectors++;
    if (state !== IDLE) begin
      miscompares++; $display("FAIL mid_state: got %0d want %0d", state, IDLE);
    end
    vectors++;
    if ({req_ack, app_en, app_wdf_wren, done, err} !== 5'b0 || app_cmd !== 3'b001) begin
      miscompares++;
      $display("FAIL mid_outputs: got %b cmd=%b want 00000 cmd=001", {req_ack, app_en, app_wdf_wren, done, err}, app_cmd);
    end
    vectors++;
    if ({num_strips, strip_cnt, rd_strip_cnt} !== 18'h0 || addr_base !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_regs: got ns=%0d sc=%0d rc=%0d ab=%h want all 0", num_strips, strip_cnt, rd_strip_cnt, addr_base);
    end
    run_burst(1'b0, 32'h0000_3458, 6'd1, 0, 0, 1'b0);
    vectors++;
    if (!seen_done || addr_base !== 32'h0000_3450) begin
      miscompares++; $display("FAIL mid_follow: got done=%b ab=%h want 1/00003450", seen_done, addr_base);
    end
    vectors++;
    if (cmd_cnt !== 2 || beats !== 2) begin
      miscompares++; $display("FAIL mid_follow_counts: got cmd=%0d beats=%0d want 2/2", cmd_cnt, beats);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    run_burst(1'b0, 32'h0000_0500, 6'd1, 0, 0, 1'b1);
    vectors++;
    if (!seen_done) begin
      miscompares++; $display("FAIL b2b_timeout: got no done want done");
    end
    vectors++;
    if (ack_cnt !== 1) begin
      miscompares++; $display("FAIL b2b_single_ack: got %0d want 1", ack_cnt);
    end
    tick();
    vectors++;
    if (req_ack !== 1'b1 || state !== PRESET1) begin
      miscompares++; $display("FAIL b2b_second_ack: got ack=%b st=%0d want 1/%0d", req_ack, state, PRESET1);
    end
    req = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (state !== IDLE) begin
      miscompares++; $display("FAIL b2b_cleanup: got %0d want %0d", state, IDLE);
    end
  endtask

`ifdef MPMC10_TIMEOUT_EN
  task automatic test_timeout();
    int   rd1_first, err_cyc;
    logic seen_err, seen_dn;
    rd1_first = -1; err_cyc = -1; seen_err = 1'b0; seen_dn = 1'b0;
    req = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0700; req_num_strips = 6'd0;
    app_rdy = 1'b0;
    for (int c = 0; c < 100 && !seen_err; c++) begin
      tick();
      if (req_ack) req = 1'b0;
      if (state == READ_DATA1 && rd1_first < 0) rd1_first = c;
      if (done) seen_dn = 1'b1;
      if (err) begin
        seen_err = 1'b1; err_cyc = c;
      end
    end
    vectors++;
    if (!seen_err || err_cyc - rd1_first !== 15) begin
      miscompares++; $display("FAIL to_err_cycle: got seen=%b off=%0d want 1/15", seen_err, err_cyc - rd1_first);
    end
    vectors++;
    if (state !== IDLE || app_en !== 1'b0 || seen_dn !== 1'b0) begin
      miscompares++; $display("FAIL to_abort: got st=%0d en=%b done=%b want %0d/0/0", state, app_en, seen_dn, IDLE);
    end
    tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++; $display("FAIL to_err_pulse: got %b want 0", err);
    end
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; req = 1'b0; req_we = 1'b0; req_adr = '0; req_num_strips = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data_valid = 1'b0;
    test_reset();
    test_stray_inputs();
    test_read_burst();
    test_read_stall();
    test_write();
    test_reset_mid_burst();
    test_back_to_back();
`ifdef MPMC10_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
